// File: rtl/leg_wb_pkg.sv
// leg_wb_pkg: shared types for the posted-write buffer.
`default_nettype none

package leg_wb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Default-width entry; the top redeclares it locally to follow its AW/DW.
  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
    logic [2:0]       size;
  } wb_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WDRAIN = 2'd1,
    RDPASS = 2'd2
  } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// wb_fifo: circular FIFO with extra-MSB pointers and registered full/empty.
// Rev 1.0
`default_nettype none

module wb_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty,
  output logic one_left
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] wr_ptr, rd_ptr, wr_next, rd_next;
  logic        do_push, do_pop;
  T            mem [DEPTH];

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_next = wr_ptr + {{PW{1'b0}}, do_push};
    rd_next = rd_ptr + {{PW{1'b0}}, do_pop};
  end

  // Flags are computed from the next pointers so they are valid right after the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      full   <= (wr_next[PW] != rd_next[PW]) && (wr_next[PW-1:0] == rd_next[PW-1:0]);
      empty  <= (wr_next == rd_next);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

  assign dout     = mem[rd_ptr[PW-1:0]];
  assign one_left = ((wr_ptr - rd_ptr) == {{PW{1'b0}}, 1'b1});

endmodule

`default_nettype wire

// File: rtl/write_buffer.sv
// write_buffer: posted-write buffer between D$ bus master and the AHB arbiter.
// Rev 1.0
`default_nettype none

module write_buffer
  import leg_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          HRequestM,
  input  logic          HWriteM,
  input  logic [AW-1:0] HAddrM,
  input  logic [DW-1:0] HWDataM,
  input  logic [2:0]    HSizeM,
  output logic          HReadyM,
  output logic          HRequestWB,
  output logic          HWriteWB,
  output logic [AW-1:0] HAddrWB,
  output logic [DW-1:0] HWDataWB,
  output logic [2:0]    HSizeWB,
  input  logic          HReadyWB,
  input  logic          DrainReq,
  output logic          WBEmpty
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [2:0]    size;
  } entry_t;

  wb_state_t state, state_next;
  entry_t    din, head;
  logic      full, empty, one_left;
  logic      write_ok, pop;
  logic      drain_unused;

  // Draining is always eager, so the CP15 request only needs WBEmpty.
  assign drain_unused = DrainReq;

  assign write_ok = HRequestM & HWriteM & ~full & ~reset;
  assign din      = '{addr: HAddrM, data: HWDataM, size: HSizeM};

  wb_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (write_ok),
    .pop      (pop),
    .din      (din),
    .dout     (head),
    .full     (full),
    .empty    (empty),
    .one_left (one_left)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    HRequestWB = 1'b0;
    HWriteWB   = 1'b0;
    HAddrWB    = '0;
    HWDataWB   = '0;
    HSizeWB    = '0;
    HReadyM    = write_ok;
    case (state)
      IDLE: begin
        // A write accepted this cycle starts the drain without an idle bubble.
        if (!empty || write_ok)          state_next = WDRAIN;
        else if (HRequestM && !HWriteM)  state_next = RDPASS;
      end
      WDRAIN: begin
        HRequestWB = 1'b1;
        HWriteWB   = 1'b1;
        HAddrWB    = head.addr;
        HWDataWB   = head.data;
        HSizeWB    = head.size;
        if (HReadyWB) begin
          pop = 1'b1;
          if (one_left && !write_ok) state_next = IDLE;
        end
      end
      RDPASS: begin
        HRequestWB = 1'b1;
        HAddrWB    = HAddrM;
        HSizeWB    = HSizeM;
        HReadyM    = HReadyWB & ~reset;
        if (HReadyWB) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign WBEmpty = empty & (state != WDRAIN);

endmodule

`default_nettype wire

// File: tb/tb_write_buffer.sv
// tb_write_buffer: directed self-checking bench for write_buffer.
`default_nettype none

module tb_write_buffer;
  import leg_wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        HRequestM, HWriteM;
  logic [31:0] HAddrM, HWDataM;
  logic [2:0]  HSizeM;
  logic        HReadyM;
  logic        HRequestWB, HWriteWB;
  logic [31:0] HAddrWB, HWDataWB;
  logic [2:0]  HSizeWB;
  logic        HReadyWB, DrainReq, WBEmpty;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  write_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .HRequestM(HRequestM), .HWriteM(HWriteM), .HAddrM(HAddrM),
    .HWDataM(HWDataM), .HSizeM(HSizeM), .HReadyM(HReadyM),
    .HRequestWB(HRequestWB), .HWriteWB(HWriteWB), .HAddrWB(HAddrWB),
    .HWDataWB(HWDataWB), .HSizeWB(HSizeWB), .HReadyWB(HReadyWB),
    .DrainReq(DrainReq), .WBEmpty(WBEmpty)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put_write(input logic [31:0] a, input logic [31:0] d);
    HRequestM = 1'b1; HWriteM = 1'b1; HAddrM = a; HWDataM = d; HSizeM = HSIZE_WORD;
  endtask

  task automatic idle_m();
    HRequestM = 1'b0; HWriteM = 1'b0; HAddrM = '0; HWDataM = '0; HSizeM = '0;
  endtask

  logic [63:0] q[$];
  logic [63:0] front;
  int          sent, drained, budget;

  initial begin
    reset = 1'b1; DrainReq = 1'b0; HReadyWB = 1'b0;
    put_write(32'h0000_0040, 32'h1111_1111);
    cyc(); cyc();
    #1;
    chk("rst_hreadym", HReadyM, 0);
    chk("rst_hrequestwb", HRequestWB, 0);
    chk("rst_wbempty", WBEmpty, 1);
    chk("rst_haddrwb", HAddrWB, 0);

    // Single write with an always-ready bus
    cyc(); reset = 1'b0;
    put_write(32'h100, 32'hDEAD_BEEF); HReadyWB = 1'b1; #1;
    chk("w1_hreadym", HReadyM, 1);
    cyc(); idle_m(); #1;
    chk("w1_req", HRequestWB, 1);
    chk("w1_write", HWriteWB, 1);
    chk("w1_addr", HAddrWB, 32'h100);
    chk("w1_data", HWDataWB, 32'hDEAD_BEEF);
    chk("w1_size", HSizeWB, HSIZE_WORD);
    chk("w1_busy", WBEmpty, 0);
    cyc(); #1;
    chk("w1_empty", WBEmpty, 1);
    chk("w1_idle_req", HRequestWB, 0);

    // Fill to DEPTH, fifth write stalls
    HReadyWB = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(); put_write(32'h300 + 32'(4 * i), 32'(i)); #1;
      chk("fill_accept", HReadyM, 1);
    end
    cyc(); put_write(32'h310, 32'hF5); #1;
    chk("fill_stall", HReadyM, 0);
    chk("fill_head_stable", HAddrWB, 32'h300);
    cyc(); HReadyWB = 1'b1; #1;
    chk("fill_pop_cycle_stall", HReadyM, 0);
    cyc(); HReadyWB = 1'b0; #1;
    chk("fill_late_accept", HReadyM, 1);
    chk("fill_new_head", HAddrWB, 32'h304);
    cyc(); idle_m(); HReadyWB = 1'b1; #1;
    for (int j = 1; j <= 4; j++) begin
      chk("fill_drain_addr", HAddrWB, 32'h300 + 32'(4 * j));
      chk("fill_drain_data", HWDataWB, (j < 4) ? 32'(j) : 32'hF5);
      cyc(); #1;
    end
    chk("fill_done_empty", WBEmpty, 1);

    // Two writes then a read, two-cycle bus transfers
    HReadyWB = 1'b0;
    put_write(32'h200, 32'hA0A0_A0A0); #1;
    chk("rw_w1_accept", HReadyM, 1);
    cyc(); put_write(32'h204, 32'hB0B0_B0B0); #1;
    chk("rw_w2_accept", HReadyM, 1);
    chk("rw_t1a_addr", HAddrWB, 32'h200);
    chk("rw_t1a_write", HWriteWB, 1);
    cyc(); HRequestM = 1'b1; HWriteM = 1'b0; HAddrM = 32'h200; HSizeM = HSIZE_WORD;
    HReadyWB = 1'b1; #1;
    chk("rw_t1b_addr", HAddrWB, 32'h200);
    chk("rw_read_stall1", HReadyM, 0);
    cyc(); HReadyWB = 1'b0; #1;
    chk("rw_t2a_addr", HAddrWB, 32'h204);
    chk("rw_t2a_write", HWriteWB, 1);
    chk("rw_read_stall2", HReadyM, 0);
    cyc(); HReadyWB = 1'b1; #1;
    chk("rw_t2b_addr", HAddrWB, 32'h204);
    chk("rw_read_stall3", HReadyM, 0);
    cyc(); HReadyWB = 1'b0; #1;
    chk("rw_idle_req", HRequestWB, 0);
    chk("rw_read_stall4", HReadyM, 0);
    cyc(); #1;
    chk("rw_rd_req", HRequestWB, 1);
    chk("rw_rd_write", HWriteWB, 0);
    chk("rw_rd_addr", HAddrWB, 32'h200);
    chk("rw_rd_wait", HReadyM, 0);
    cyc(); HReadyWB = 1'b1; #1;
    chk("rw_rd_done", HReadyM, 1);
    chk("rw_rd_wdata", HWDataWB, 0);
    cyc(); idle_m(); HReadyWB = 1'b0; #1;
    chk("rw_back_idle", HRequestWB, 0);

    // Ten writes with a random-ready bus, across pointer wrap
    sent = 0; drained = 0; budget = 0;
    while ((drained < 10) && (budget < 400)) begin
      cyc();
      if (sent < 10) put_write(32'h1000 + 32'(sent * 8), 32'hC000_0000 + 32'(sent));
      else idle_m();
      HReadyWB = 1'($urandom_range(0, 1));
      #1;
      if (HRequestWB && HReadyWB) begin
        front = (q.size() > 0) ? q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
        chk("wrap_order", {HAddrWB, HWDataWB}, front);
        drained++;
      end
      if (HRequestM && HReadyM) begin
        q.push_back({HAddrM, HWDataM});
        sent++;
      end
      budget++;
    end
    chk("wrap_all_drained", 64'(drained), 10);
    cyc(); idle_m(); HReadyWB = 1'b0; #1;
    chk("wrap_empty", WBEmpty, 1);

    // Reset while draining
    for (int i = 0; i < 3; i++) begin
      cyc(); put_write(32'h700 + 32'(4 * i), 32'(i)); #1;
    end
    cyc(); idle_m(); #1;
    chk("rstd_draining", HRequestWB, 1);
    reset = 1'b1;
    cyc(); reset = 1'b0; #1;
    chk("rstd_req", HRequestWB, 0);
    chk("rstd_empty", WBEmpty, 1);
    chk("rstd_state", 64'(dut.state), 64'(IDLE));
    put_write(32'h400, 32'h4444_4444); #1;
    chk("rstd_accept", HReadyM, 1);
    cyc(); idle_m(); HReadyWB = 1'b1; #1;
    chk("rstd_new_head", HAddrWB, 32'h400);
    cyc(); HReadyWB = 1'b0; #1;
    chk("rstd_done", WBEmpty, 1);

    // CP15 drain status with two entries
    DrainReq = 1'b1;
    put_write(32'h500, 32'h5); #1;
    cyc(); put_write(32'h504, 32'h6); #1;
    cyc(); idle_m(); #1;
    chk("drn_busy0", WBEmpty, 0);
    cyc(); HReadyWB = 1'b1; #1;
    chk("drn_busy1", WBEmpty, 0);
    cyc(); #1;
    chk("drn_busy2", WBEmpty, 0);
    cyc(); HReadyWB = 1'b0; #1;
    chk("drn_empty", WBEmpty, 1);
    DrainReq = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/write_buffer.md
Name: write_buffer

Overview:
- Posted-write buffer between the data cache's bus master port and the 3-way AHB arbiter's data-side port.
- Accepts D$ write transactions (write-through stores and dirty-line writebacks) in one cycle when space exists, then drains them to the bus in order.
- Reads pass through only after the buffer is empty, so bus ordering matches program order.
- Also provides the CP15 "drain write buffer" status.

Parameters:
- DEPTH, 4, number of entries; power of 2, at least 2.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high
- HRequestM  input  1  D$ bus request
- HWriteM  input  1  D$ request is a write
- HAddrM  input  AW  D$ address
- HWDataM  input  DW  D$ write data
- HSizeM  input  3  D$ transfer size
- HReadyM  output  1  transfer complete/accepted, to D$
- HRequestWB  output  1  request to arbiter
- HWriteWB  output  1  write flag to arbiter
- HAddrWB  output  AW  address to arbiter
- HWDataWB  output  DW  write data to arbiter
- HSizeWB  output  3  size to arbiter
- HReadyWB  input  1  arbiter/bus completion for the current WB transfer
- DrainReq  input  1  CP15 drain/clean request, level
- WBEmpty  output  1  no entries and no write in flight

Behaviour:
- Storage: circular FIFO of {addr, data, size}.
  - Pointers are log2(DEPTH)+1 bits.
  - Full when pointers differ only in the MSB; empty when pointers are equal.
- Enqueue:
  - When HRequestM & HWriteM & ~full & ~reset, HReadyM = 1 combinationally in the same cycle.
  - The entry is written at that clock edge, so the D$ sees 0 wait states.
  - The full flag is registered. A pop in the same cycle as a full-buffer write does not admit the write; the write is accepted the next cycle.
- FSM states, registered: IDLE, WDRAIN, RDPASS.
- IDLE:
  - If not empty, go to WDRAIN.
  - Else if HRequestM & ~HWriteM, go to RDPASS.
  - Outputs: HRequestWB = 0.
- WDRAIN:
  - HRequestWB = 1 and HWriteWB = 1; HAddrWB, HWDataWB and HSizeWB come from the head entry.
  - On HReadyWB, pop the head. If count becomes 0, go to IDLE; otherwise stay.
  - The head entry must stay stable while waiting.
- RDPASS:
  - HRequestWB = 1 and HWriteWB = 0; HAddrWB and HSizeWB = D$ inputs; HWDataWB = 0.
  - HReadyM = HReadyWB.
  - On HReadyWB, go to IDLE. The read is never abandoned mid-transfer.
- Read stall: a read request while the buffer is non-empty or the FSM is in WDRAIN gets HReadyM = 0 until the read completes in RDPASS. Minimum read latency from IDLE with an empty buffer is 1 cycle plus bus latency.
- Writes arriving during RDPASS are impossible, because the D$ holds its one request. Writes arriving during WDRAIN enqueue normally.
- DrainReq has no effect on the FSM, since draining is always eager. WBEmpty = empty & (state != WDRAIN) lets CP15 stall until 1.
- Reset (synchronous):
  - Pointers = 0, state = IDLE.
  - All outputs 0 except WBEmpty = 1; HReadyM is forced 0 during reset.
  - Entries pending at reset are discarded, including any in-flight write.
- Simultaneous enqueue and dequeue on a non-full buffer: count is unchanged, both pointers advance.
- Pointer wrap: the index wraps modulo DEPTH; the MSB toggles on wrap.

Decomposition:
- Package leg_wb_pkg:
  - wb_entry_t packed struct {addr, data, size}
  - wb_state_t enum {IDLE, WDRAIN, RDPASS}
  - HSIZE encodings: byte 3'b000, half 3'b001, word 3'b010.
- Sub-module wb_fifo #(DEPTH, type T):
  - push, pop, din, dout, full, empty
  - registered flags; contents not reset.
- The top-level write_buffer holds the FSM and muxing.

Test Plan:
- Single write, empty buffer, HReadyWB held high: store 0xDEADBEEF at 0x100, word size.
  - Required: HReadyM = 1 in the same cycle; HRequestWB = 1 with addr 0x100 on the next cycle; WBEmpty = 1 two cycles later.
- Fill: 5 back-to-back writes with HReadyWB = 0 and DEPTH = 4.
  - Required: first 4 get HReadyM = 1, the 5th stalls.
  - Then pulse HReadyWB once: the 5th is accepted on the following cycle, not the pop cycle.
- Read after writes: 2 writes (0x200, 0x204) then a read of 0x200, with the bus taking 2 cycles per transfer.
  - Required: bus order is W 0x200, W 0x204, R 0x200.
  - Required: HReadyM for the read rises only with its HReadyWB.
- Wrap-around: 10 writes with random HReadyWB.
  - Required: the drained address/data sequence equals the enqueue order across the pointer wrap.
- Reset mid-drain: 3 entries queued, reset asserted during WDRAIN.
  - Required next cycle: HRequestWB = 0, WBEmpty = 1, state IDLE; a later write is accepted normally.
- Drain status: DrainReq = 1 with 2 entries queued.
  - Required: WBEmpty = 0 until the second HReadyWB, then 1 the next cycle.
